fp_normalize_round: RTL and testbench

//  Post-add stage of the FP32 add/sub datapath. Mirrors the pre-add alignment shifter:
//  it takes the raw significand sum and the G/R/S bits produced by alignment, then normalises
//  it (1-bit right shift on carry, or left shift by the leading-zero count), rounds to nearest

---
 rtl/fp_norm_pkg.sv | 23 ++
 rtl/fp_lzc24.sv | 27 ++
 rtl/fp_normalize_round.sv | 158 +++++++++++++++
 tb/tb_fp_normalize_round.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_norm_pkg.sv
// Shared constants and the stage-1 record for the FP32 post-add normalise/round block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_norm_pkg;

  localparam int EXP_W = 8;   // biased exponent width
  localparam int MAN_W = 24;  // significand width including the hidden bit

  localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
  localparam int BIAS = 127;

  // Normalised beat held between the normalise and round stages.
  // exp is wide and signed so that exp+1 from a carry (256) is representable.
  typedef struct packed {
    logic              sign;
    logic signed [9:0] exp;
    logic [MAN_W-1:0]  man;
    logic [2:0]        grs;   // {G,R,S} below man[0]
    logic              zero;  // exact zero
    logic              uf;    // nonzero value flushed to zero
  } s1_t;

endpackage

// File: rtl/fp_lzc24.sv
// Leading-zero counter for a 24-bit significand.
// Latency: combinational.
// Backpressure: none.
//   in_i   24-bit value
//   cnt_o  number of leading zeros (0..23; 24 when in_i is zero)
//   vld_o  high when in_i has at least one set bit
module fp_lzc24 (
  input  logic [23:0] in_i,
  output logic [4:0]  cnt_o,
  output logic        vld_o
);

  always_comb begin
    cnt_o = 5'd0;
    vld_o = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (!vld_o && in_i[i]) begin
        cnt_o = 5'(23 - i);
        vld_o = 1'b1;
      end
    end
    if (!vld_o) begin
      cnt_o = 5'd24;
    end
  end

endmodule

// File: rtl/fp_normalize_round.sv
// FP32 add/sub post-add stage: normalise the raw sum, round to nearest even, pack.
// Latency: 2 cycles (S1 normalise register, S2 round/pack register), 1 beat/cycle.
// Backpressure: valid/ready both sides; S2 holds while !ready_i, S1 fills, then ready_o drops.
//   clk_i, rst_ni       clock (rising edge), asynchronous active-low reset
//   valid_i/ready_o     input handshake; sign_i, exp_i[7:0], sig_i[24:0], guard_i[2:0] = {G,R,S}
//   valid_o/ready_i     output handshake; result_o[31:0] = {sign,exp,frac}
//   flags_o[2:0]        {OF,UF,NX}, present only when FP_NORM_FLAGS_EN is defined
module fp_normalize_round
  import fp_norm_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   sign_i,
  input  logic [EXP_W-1:0]       exp_i,
  input  logic [MAN_W:0]         sig_i,
  input  logic [2:0]             guard_i,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [EXP_W+MAN_W-1:0] result_o
`ifdef FP_NORM_FLAGS_EN
  ,
  output logic [2:0]             flags_o
`endif
);

  localparam int RES_W = EXP_W + MAN_W;

  // ---------------- handshake ----------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_ld, s1_adv, in_fire;

  assign s2_ld   = !s2_valid_q || ready_i;
  assign s1_adv  = s1_valid_q && s2_ld;
  assign ready_o = !s1_valid_q || s1_adv;
  assign in_fire = valid_i && ready_o;

  // ---------------- S1: normalise ----------------
  logic [4:0]       lz;
  logic             lz_vld;
  logic [MAN_W+1:0] shl_vec;
  s1_t              norm;
  s1_t              s1_q, s1_d;

  fp_lzc24 u_lzc (
    .in_i  (sig_i[MAN_W-1:0]),
    .cnt_o (lz),
    .vld_o (lz_vld)
  );

  always_comb begin
    // G and R ride along under the left shift; zeros fill behind them, S stays put.
    shl_vec   = {sig_i[MAN_W-1:0], guard_i[2:1]} << lz;
    norm      = '0;
    norm.sign = sign_i;
    if (sig_i[MAN_W]) begin
      norm.man = sig_i[MAN_W:1];
      norm.exp = $signed({2'b00, exp_i} + 10'd1);
      norm.grs = {sig_i[0], guard_i[2], guard_i[1] | guard_i[0]};
    end else if (!lz_vld && guard_i == 3'b000) begin
      norm.zero = 1'b1;
    end else if (!lz_vld || ({3'b000, lz} >= exp_i)) begin
      // Result would be subnormal (or only guard bits survive cancellation,
      // which a real subtraction never produces): flush to signed zero.
      norm.uf = 1'b1;
    end else begin
      norm.man = shl_vec[MAN_W+1:2];
      norm.exp = $signed({2'b00, exp_i} - {5'd0, lz});
      norm.grs = {shl_vec[1:0], guard_i[0]};
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d       = norm;
    end
  end

  // ---------------- S2: round to nearest even and pack ----------------
  logic                    inc;
  logic [MAN_W:0]          man_rnd;
  logic signed [9:0]       exp_rnd;
  logic [MAN_W-2:0]        frac;
  logic                    ovf;
  logic [RES_W-1:0]        packed_res;
  logic [RES_W-1:0]        result_q, result_d;

  always_comb begin
    inc     = s1_q.grs[2] & (s1_q.grs[1] | s1_q.grs[0] | s1_q.man[0]);
    man_rnd = {1'b0, s1_q.man} + {{MAN_W{1'b0}}, inc};
    // A rounding carry renormalises by one place and bumps the exponent.
    exp_rnd = s1_q.exp + (man_rnd[MAN_W] ? 10'sd1 : 10'sd0);
    frac    = man_rnd[MAN_W] ? man_rnd[MAN_W-1:1] : man_rnd[MAN_W-2:0];
    ovf     = !s1_q.zero && !s1_q.uf && (exp_rnd >= 10'sd255);
    if (s1_q.zero || s1_q.uf) begin
      packed_res = {s1_q.sign, {(RES_W-1){1'b0}}};
    end else if (ovf) begin
      packed_res = {s1_q.sign, EXP_MAX, {(MAN_W-1){1'b0}}};
    end else begin
      packed_res = {s1_q.sign, exp_rnd[EXP_W-1:0], frac};
    end
  end

  always_comb begin
    s2_valid_d = s2_ld ? s1_valid_q : s2_valid_q;
    result_d   = result_q;
    if (s1_adv) begin
      result_d = packed_res;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_q       <= s1_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
    end
  end

  assign valid_o  = s2_valid_q;
  assign result_o = result_q;

`ifdef FP_NORM_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  always_comb begin
    flags_d = flags_q;
    if (s1_adv) begin
      flags_d = {ovf, s1_q.uf, (|s1_q.grs) | ovf | s1_q.uf};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q <= 3'b000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
// Bench for fp_normalize_round: directed vectors with hand-computed results, a numeric
// reference model feeding a scoreboard checked on every output transfer, backpressure,
// random stall patterns and a mid-stream reset.
module tb_fp_normalize_round;

  logic        clk;
  logic        rst_ni;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [24:0] sig_i;
  logic [2:0]  guard_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
`ifdef FP_NORM_FLAGS_EN
  logic [2:0]  flags_o;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  fp_normalize_round dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .sign_i   (sign_i),
    .exp_i    (exp_i),
    .sig_i    (sig_i),
    .guard_i  (guard_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
`ifdef FP_NORM_FLAGS_EN
    ,
    .flags_o  (flags_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Reference: treat {sig,G,R} as an integer, locate its leading one, take the 24 bits
  // under it as the mantissa and the next two as G/R, fold everything lower into S,
  // then round-nearest-even and pack. Returns {OF,UF,NX,result}.
  function automatic logic [34:0] model(input logic sgn, input logic [7:0] e_in,
                                        input logic [24:0] sig, input logic [2:0] grs);
    int p, e, k;
    logic [63:0] y, man;
    logic g, r, st, of, uf, nx;
    logic [31:0] res;
    of = 1'b0; uf = 1'b0; nx = 1'b0;
    res = {sgn, 31'd0};
    if (sig == 25'd0) begin
      uf = (grs != 3'b000);
    end else begin
      p = 0;
      for (int i = 0; i < 25; i++) if (sig[i]) p = i;
      e = int'(e_in) + p - 23;
      if (e <= 0) begin
        uf = 1'b1;
      end else begin
        y   = 64'({sig, grs[2:1]}) << 30;
        k   = p + 32;                      // bit index of the leading one in y
        man = (y >> (k - 23)) & 64'hFFFFFF;
        g   = y[k-24];
        r   = y[k-25];
        st  = grs[0] | ((y & ((64'd1 << (k - 25)) - 64'd1)) != 64'd0);
        nx  = g | r | st;
        if (g && (r || st || man[0])) man = man + 64'd1;
        if (man == 64'h1000000) begin
          man = 64'h800000;
          e++;
        end
        if (e >= 255) begin
          of  = 1'b1;
          res = {sgn, 8'hFF, 23'd0};
        end else begin
          res = {sgn, 8'(e), man[22:0]};
        end
      end
    end
    nx = nx | of | uf;
    return {of, uf, nx, res};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [34:0] exp_q[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic [2:0]  prev_flg;

  always @(negedge clk) begin
    logic [34:0] e;
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h with no beat outstanding", result_o);
        end else begin
          e = exp_q.pop_front();
          chk("result", 64'(result_o), 64'(e[31:0]));
`ifdef FP_NORM_FLAGS_EN
          chk("flags", 64'(flags_o), 64'(e[34:32]));
`endif
        end
      end
      if (valid_o && !ready_i) begin
        if (prev_stall) begin
          chk("stall_hold_result", 64'(result_o), 64'(prev_res));
`ifdef FP_NORM_FLAGS_EN
          chk("stall_hold_flags", 64'(flags_o), 64'(prev_flg));
`endif
        end
        prev_stall = 1'b1;
        prev_res   = result_o;
`ifdef FP_NORM_FLAGS_EN
        prev_flg   = flags_o;
`else
        prev_flg   = 3'b000;
`endif
      end else begin
        prev_stall = 1'b0;
      end
      if (valid_i && ready_o) exp_q.push_back(model(sign_i, exp_i, sig_i, guard_i));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Present one beat and return just after the edge that accepted it.
  task automatic drive(input logic s, input logic [7:0] e, input logic [24:0] sg,
                       input logic [2:0] g);
    int n;
    sign_i = s; exp_i = e; sig_i = sg; guard_i = g; valid_i = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: ready_o stuck at 0 for %0d cycles, want 1", n);
      valid_i = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
  endtask

  // Directed beat: pin the model to the hand-computed answer, then send it.
  task automatic apply(input logic s, input logic [7:0] e, input logic [24:0] sg,
                       input logic [2:0] g, input logic [31:0] want_res,
                       input logic [2:0] want_flg);
    logic [34:0] m;
    m = model(s, e, sg, g);
    chk("model_result", 64'(m[31:0]), 64'(want_res));
    chk("model_flags", 64'(m[34:32]), 64'(want_flg));
    drive(s, e, sg, g);
  endtask

  task automatic drain();
    int n;
    valid_i = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  bit rnd_done;

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    sign_i = 1'b0; exp_i = 8'd0; sig_i = 25'd0; guard_i = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    chk("rst_result_o", 64'(result_o), 64'd0);
`ifdef FP_NORM_FLAGS_EN
    chk("rst_flags_o", 64'(flags_o), 64'd0);
`endif
    rst_ni = 1'b1;
    @(posedge clk);
    #1;

    // 1.0 + 1.0 with explicit two-cycle latency check
    apply(1'b0, 8'd127, 25'h1000000, 3'b000, 32'h40000000, 3'b000);
    valid_i = 1'b0;
    chk("latency_cycle1_valid", 64'(valid_o), 64'd0);
    @(posedge clk);
    #1;
    chk("latency_cycle2_valid", 64'(valid_o), 64'd1);
    chk("latency_cycle2_result", 64'(result_o), 64'h40000000);

    // Back-to-back directed stream
    apply(1'b0, 8'd150, 25'h0000001, 3'b000, 32'h3F800000, 3'b000); // cancellation lz=23
    apply(1'b0, 8'd127, 25'h0800001, 3'b100, 32'h3F800002, 3'b001); // tie, odd -> up
    apply(1'b0, 8'd127, 25'h0800000, 3'b100, 32'h3F800000, 3'b001); // tie, even -> stay
    apply(1'b0, 8'd127, 25'h0FFFFFF, 3'b110, 32'h40000000, 3'b001); // rounding carry
    apply(1'b0, 8'd254, 25'h1000000, 3'b000, 32'h7F800000, 3'b101); // overflow
    apply(1'b0, 8'd254, 25'h0FFFFFF, 3'b100, 32'h7F800000, 3'b101); // carry into inf
    apply(1'b0, 8'd10,  25'h0000100, 3'b000, 32'h00000000, 3'b011); // underflow flush
    apply(1'b1, 8'd5,   25'h0000000, 3'b000, 32'h80000000, 3'b000); // exact -0
    drain();

    // Backpressure: two beats fill both stages, then ready_o must drop
    ready_i = 1'b0;
    apply(1'b1, 8'd130, 25'h0C00000, 3'b000, 32'hC1400000, 3'b000); // -12.0
    apply(1'b0, 8'd1,   25'h0800000, 3'b000, 32'h00800000, 3'b000); // min normal
    chk("bp_ready_o_low", 64'(ready_o), 64'd0);
    chk("bp_valid_o_high", 64'(valid_o), 64'd1);
    fork
      begin
        apply(1'b0, 8'd1,   25'h0400000, 3'b000, 32'h00000000, 3'b011); // just subnormal
        apply(1'b0, 8'd127, 25'h1000003, 3'b000, 32'h40000002, 3'b001); // carry + RNE
        valid_i = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_i = 1'b1;
      end
    join
    drain();

    // Random operands under random output stalls
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          logic [24:0] sg;
          case ($urandom_range(0, 3))
            0:       sg = {1'b1, 24'($urandom)};
            1:       sg = {2'b01, 23'($urandom)};
            2:       sg = 25'($urandom) >> $urandom_range(2, 24);
            default: sg = 25'($urandom_range(0, 255));
          endcase
          drive(1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), sg,
                3'($urandom_range(0, 7)));
        end
        valid_i  = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    ready_i = 1'b1;
    drain();

    // Reset with two beats in flight
    ready_i = 1'b0;
    drive(1'b0, 8'd127, 25'h1000000, 3'b000);
    drive(1'b0, 8'd150, 25'h0000001, 3'b000);
    valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_valid_o", 64'(valid_o), 64'd0);
    chk("midrst_ready_o", 64'(ready_o), 64'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    chk("midrst_valid_o_edge", 64'(valid_o), 64'd0);
    rst_ni  = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    apply(1'b0, 8'd127, 25'h0800000, 3'b000, 32'h3F800000, 3'b000);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
